// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the multicycle RV64 datapath and a doubleword-addressed data memory.
// Sub-doubleword stores are done as read-modify-write; faults are reported with a cause code.
module lsu_mem_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause,
    output logic [63:0] fault_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} stateType;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;
    localparam logic [7:0] TIMEOUT_LAST     = 8'(MEM_TIMEOUT - 1);

    stateType    state;
    logic [63:0] addrReg;
    logic [2:0]  func3Reg;
    logic        writeReg;
    logic [63:0] wdataReg;
    logic [7:0]  timeoutCnt;

    logic        reqIllegal;
    logic        reqMisaligned;
    logic        reqFullStore;
    logic        timeoutHit;
    logic [5:0]  laneShift;
    logic [63:0] shiftedData;
    logic [63:0] loadData;
    logic [63:0] laneMask;
    logic [63:0] mergedData;

    // Request decode happens on the live inputs, since it only matters in the accept cycle.
    always_comb begin
        reqIllegal    = req_write ? req_func3[2] : (req_func3 == 3'b111);
        reqMisaligned = 1'b0;
        case (req_func3[1:0])
            2'b01:   reqMisaligned = req_addr[0];
            2'b10:   reqMisaligned = |req_addr[1:0];
            2'b11:   reqMisaligned = |req_addr[2:0];
            default: reqMisaligned = 1'b0;
        endcase
        reqFullStore = req_write && (req_func3[1:0] == 2'b11);
        timeoutHit   = (timeoutCnt == TIMEOUT_LAST);
    end

    // Lane extraction for loads and lane merging for RMW stores both use the captured offset.
    always_comb begin
        laneShift   = {addrReg[2:0], 3'b000};
        shiftedData = mem_rdata >> laneShift;
        case (func3Reg)
            3'b000:  loadData = {{56{shiftedData[7]}}, shiftedData[7:0]};
            3'b001:  loadData = {{48{shiftedData[15]}}, shiftedData[15:0]};
            3'b010:  loadData = {{32{shiftedData[31]}}, shiftedData[31:0]};
            3'b100:  loadData = {56'd0, shiftedData[7:0]};
            3'b101:  loadData = {48'd0, shiftedData[15:0]};
            3'b110:  loadData = {32'd0, shiftedData[31:0]};
            default: loadData = shiftedData;
        endcase
        case (func3Reg[1:0])
            2'b00:   laneMask = 64'h0000_0000_0000_00FF;
            2'b01:   laneMask = 64'h0000_0000_0000_FFFF;
            2'b10:   laneMask = 64'h0000_0000_FFFF_FFFF;
            default: laneMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mergedData = (mem_rdata & ~(laneMask << laneShift)) | ((wdataReg & laneMask) << laneShift);
    end

    // Main controller: every output is a register updated alongside the state transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addrReg    <= '0;
            func3Reg   <= '0;
            writeReg   <= 1'b0;
            wdataReg   <= '0;
            timeoutCnt <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            rsp_cause  <= '0;
            fault_addr <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addrReg    <= req_addr;
                        func3Reg   <= req_func3;
                        writeReg   <= req_write;
                        wdataReg   <= req_wdata;
                        timeoutCnt <= '0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (reqIllegal || reqMisaligned) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_cause  <= reqIllegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                            rsp_rdata  <= '0;
                            fault_addr <= req_addr;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {req_addr[63:3], 3'b000};
                            if (reqFullStore) begin
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                state  <= RD;
                                mem_we <= 1'b0;
                            end
                        end
                    end
                end
                RD, WR: begin
                    if (mem_ack) begin
                        timeoutCnt <= '0;
                        if (state == RD && writeReg) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= mergedData;
                        end else begin
                            state     <= RESP;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= (state == RD) ? loadData : 64'd0;
                        end
                    end else if (timeoutHit) begin
                        state      <= RESP;
                        timeoutCnt <= '0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b1;
                        rsp_cause  <= CAUSE_TIMEOUT;
                        rsp_rdata  <= '0;
                        fault_addr <= addrReg;
                    end else begin
                        timeoutCnt <= timeoutCnt + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    timeoutCnt <= '0;
                    rsp_valid  <= 1'b0;
                    rsp_err    <= 1'b0;
                    rsp_cause  <= '0;
                    rsp_rdata  <= '0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl; the bench plays the role of the data memory.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_cause;
    logic [63:0] fault_addr;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        busy;

    int assertCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_cause(rsp_cause), .fault_addr(fault_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Called at a negedge; presents one request, then scrambles inputs to prove they were captured.
    task automatic applyStimulus(input logic write, input logic [2:0] func3,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        req_valid = 1'b1;
        req_write = write;
        req_func3 = func3;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_func3 = 3'($urandom_range(0, 7));
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    // Memory responder: waits (bounded) for mem_req, holds off lat cycles, then acks once.
    task automatic serveAccess(input int lat, input logic [63:0] rdata, output logic ok,
                               output logic we, output logic [63:0] addr, output logic [63:0] wdata);
        ok = 1'b0;
        for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
        if (mem_req) begin
            repeat (lat) @(negedge clk);
            ok        = mem_req;
            we        = mem_we;
            addr      = mem_addr;
            wdata     = mem_wdata;
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        assertCount++; if (req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        assertCount++; if ({mem_req, mem_we, rsp_valid, rsp_err, busy} !== 5'b0) begin failCount++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, rsp_valid, rsp_err, busy}); end
        assertCount++; if ({fault_addr, rsp_rdata, rsp_cause} !== 130'd0) begin failCount++; $display("[TB] FAIL reset_data: got %h/%h/%b expected zeros", fault_addr, rsp_rdata, rsp_cause); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic ok, we;
        logic [63:0] a, wd;
        applyStimulus(1'b1, 3'b011, 64'h100, 64'h1122334455667788);
        serveAccess(1, 64'h0, ok, we, a, wd);
        assertCount++; if (!ok) begin failCount++; $display("[TB] FAIL sd_memreq: got timeout expected access"); end
        assertCount++; if ({we, a} !== {1'b1, 64'h100}) begin failCount++; $display("[TB] FAIL sd_cmd: got we=%b addr=%h expected we=1 addr=100", we, a); end
        assertCount++; if (wd !== 64'h1122334455667788) begin failCount++; $display("[TB] FAIL sd_wdata: got %h expected 1122334455667788", wd); end
        assertCount++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 64'd0}) begin failCount++; $display("[TB] FAIL sd_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clk);
        assertCount++; if ({rsp_valid, req_ready} !== 2'b01) begin failCount++; $display("[TB] FAIL sd_pulse: got v=%b rdy=%b expected v=0 rdy=1", rsp_valid, req_ready); end
        applyStimulus(1'b0, 3'b011, 64'h100, 64'h0);
        serveAccess(3, 64'h1122334455667788, ok, we, a, wd);
        assertCount++; if (!ok || we !== 1'b0) begin failCount++; $display("[TB] FAIL ld_cmd: got ok=%b we=%b expected ok=1 we=0", ok, we); end
        assertCount++; if ({rsp_valid, rsp_err} !== 2'b10) begin failCount++; $display("[TB] FAIL ld_rsp: got v=%b e=%b expected v=1 e=0", rsp_valid, rsp_err); end
        assertCount++; if (rsp_rdata !== 64'h1122334455667788) begin failCount++; $display("[TB] FAIL ld_data: got %h expected 1122334455667788", rsp_rdata); end
        @(negedge clk);
        assertCount++; if (rsp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL ld_pulse: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [7]   = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011};
        logic [63:0] adr [7]  = '{64'h107, 64'h107, 64'h104, 64'h104, 64'h106, 64'h106, 64'h108};
        logic [63:0] mad [7]  = '{64'h100, 64'h100, 64'h100, 64'h100, 64'h100, 64'h100, 64'h108};
        logic [63:0] rd [7]   = '{64'h8811223344556677, 64'h8811223344556677, 64'h80000001DEADBEEF,
                                  64'h80000001DEADBEEF, 64'h9ABC76543210FEDC, 64'h9ABC76543210FEDC,
                                  64'h0123456789ABCDEF};
        logic [63:0] exp [7]  = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000000088, 64'hFFFFFFFF80000001,
                                  64'h0000000080000001, 64'hFFFFFFFFFFFF9ABC, 64'h0000000000009ABC,
                                  64'h0123456789ABCDEF};
        logic ok, we;
        logic [63:0] a, wd;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, f3[i], adr[i], {$urandom, $urandom});
            serveAccess(i % 3, rd[i], ok, we, a, wd);
            assertCount++; if (!ok || a !== mad[i]) begin failCount++; $display("[TB] FAIL load%0d_addr: got ok=%b addr=%h expected %h", i, ok, a, mad[i]); end
            assertCount++; if (rsp_valid !== 1'b1) begin failCount++; $display("[TB] FAIL load%0d_valid: got %b expected 1", i, rsp_valid); end
            assertCount++; if (rsp_rdata !== exp[i]) begin failCount++; $display("[TB] FAIL load%0d_data: got %h expected %h", i, rsp_rdata, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3 [3]  = '{3'b001, 3'b000, 3'b010};
        logic [63:0] adr [3] = '{64'h102, 64'h105, 64'h104};
        logic [63:0] wv [3]  = '{64'hFFFFFFFFFFFFABCD, 64'h123456789ABCDE5A, 64'hCAFEF00DDEADBEEF};
        logic [63:0] exp [3] = '{64'h11223344ABCD7788, 64'h11225A4455667788, 64'hDEADBEEF55667788};
        logic ok, we;
        logic [63:0] a, wd;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, f3[i], adr[i], wv[i]);
            serveAccess(1, 64'h1122334455667788, ok, we, a, wd);
            assertCount++; if (!ok || {we, a} !== {1'b0, 64'h100}) begin failCount++; $display("[TB] FAIL rmw%0d_read: got ok=%b we=%b addr=%h expected we=0 addr=100", i, ok, we, a); end
            assertCount++; if ({mem_req, mem_we, rsp_valid} !== 3'b110) begin failCount++; $display("[TB] FAIL rmw%0d_turn: got req=%b we=%b v=%b expected 1 1 0", i, mem_req, mem_we, rsp_valid); end
            serveAccess(0, {$urandom, $urandom}, ok, we, a, wd);
            assertCount++; if (!ok || {we, a} !== {1'b1, 64'h100}) begin failCount++; $display("[TB] FAIL rmw%0d_write: got ok=%b we=%b addr=%h expected we=1 addr=100", i, ok, we, a); end
            assertCount++; if (wd !== exp[i]) begin failCount++; $display("[TB] FAIL rmw%0d_merge: got %h expected %h", i, wd, exp[i]); end
            assertCount++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 64'd0}) begin failCount++; $display("[TB] FAIL rmw%0d_rsp: got v=%b e=%b d=%h expected 1 0 0", i, rsp_valid, rsp_err, rsp_rdata); end
            @(negedge clk);
        end
    endtask

    task automatic test_errors();
        logic        wr [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [5]  = '{3'b010, 3'b100, 3'b111, 3'b011, 3'b001};
        logic [63:0] adr [5] = '{64'h102, 64'h200, 64'h103, 64'h104, 64'h101};
        logic [1:0]  exc [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(wr[i], f3[i], adr[i], 64'h55);
            assertCount++; if ({rsp_valid, rsp_err, rsp_cause} !== {2'b11, exc[i]}) begin failCount++; $display("[TB] FAIL err%0d_rsp: got v=%b e=%b c=%b expected 1 1 %b", i, rsp_valid, rsp_err, rsp_cause, exc[i]); end
            assertCount++; if (fault_addr !== adr[i]) begin failCount++; $display("[TB] FAIL err%0d_faddr: got %h expected %h", i, fault_addr, adr[i]); end
            assertCount++; if ({mem_req, rsp_rdata} !== 65'd0) begin failCount++; $display("[TB] FAIL err%0d_nomem: got req=%b d=%h expected 0 0", i, mem_req, rsp_rdata); end
            @(negedge clk);
            assertCount++; if ({rsp_valid, mem_req, req_ready} !== 3'b001) begin failCount++; $display("[TB] FAIL err%0d_done: got v=%b req=%b rdy=%b expected 0 0 1", i, rsp_valid, mem_req, req_ready); end
        end
    endtask

    task automatic test_timeout();
        logic        wr [2]  = '{1'b0, 1'b1};
        logic [2:0]  f3 [2]  = '{3'b011, 3'b000};
        logic [63:0] adr [2] = '{64'h300, 64'h301};
        for (int i = 0; i < 2; i++) begin
            int reqCycles = 0;
            logic weSeen = 1'b0;
            applyStimulus(wr[i], f3[i], adr[i], 64'hA5);
            for (int k = 0; k < 20; k++) begin
                if (mem_req) begin
                    reqCycles++;
                    weSeen = weSeen | mem_we;
                end else if (reqCycles > 0) begin
                    break;
                end
                @(negedge clk);
            end
            assertCount++; if (reqCycles != TIMEOUT) begin failCount++; $display("[TB] FAIL to%0d_cycles: got %0d expected %0d", i, reqCycles, TIMEOUT); end
            assertCount++; if (weSeen !== 1'b0) begin failCount++; $display("[TB] FAIL to%0d_we: got %b expected 0", i, weSeen); end
            assertCount++; if ({rsp_valid, rsp_err, rsp_cause} !== 4'b1111) begin failCount++; $display("[TB] FAIL to%0d_rsp: got v=%b e=%b c=%b expected 1 1 11", i, rsp_valid, rsp_err, rsp_cause); end
            assertCount++; if (fault_addr !== adr[i]) begin failCount++; $display("[TB] FAIL to%0d_faddr: got %h expected %h", i, fault_addr, adr[i]); end
            @(negedge clk);
            assertCount++; if ({req_ready, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL to%0d_idle: got rdy=%b busy=%b expected 1 0", i, req_ready, busy); end
        end
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        assertCount++; if ({rsp_valid, busy, mem_req, req_ready} !== 4'b0001) begin failCount++; $display("[TB] FAIL spurious_ack: got v=%b busy=%b req=%b rdy=%b expected 0 0 0 1", rsp_valid, busy, mem_req, req_ready); end
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 64'h102;
        @(negedge clk);
        assertCount++; if ({rsp_valid, req_ready} !== 2'b10) begin failCount++; $display("[TB] FAIL b2b_first: got v=%b rdy=%b expected 1 0", rsp_valid, req_ready); end
        @(negedge clk);
        assertCount++; if ({rsp_valid, req_ready} !== 2'b01) begin failCount++; $display("[TB] FAIL b2b_gap: got v=%b rdy=%b expected 0 1", rsp_valid, req_ready); end
        @(negedge clk);
        assertCount++; if ({rsp_valid, rsp_cause} !== 3'b101) begin failCount++; $display("[TB] FAIL b2b_second: got v=%b c=%b expected 1 01", rsp_valid, rsp_cause); end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic ok, we;
        logic [63:0] a, wd;
        logic sawValid = 1'b0;
        applyStimulus(1'b1, 3'b011, 64'h400, 64'h0BADF00D0BADF00D);
        assertCount++; if ({mem_req, mem_we} !== 2'b11) begin failCount++; $display("[TB] FAIL rstmid_wr: got req=%b we=%b expected 1 1", mem_req, mem_we); end
        #2 reset = 1'b0;
        #1;
        assertCount++; if ({mem_req, req_ready} !== 2'b01) begin failCount++; $display("[TB] FAIL rstmid_drop: got req=%b rdy=%b expected 0 1", mem_req, req_ready); end
        repeat (2) begin
            @(negedge clk);
            sawValid = sawValid | rsp_valid;
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            sawValid = sawValid | rsp_valid;
        end
        assertCount++; if (sawValid !== 1'b0) begin failCount++; $display("[TB] FAIL rstmid_norsp: got %b expected 0", sawValid); end
        applyStimulus(1'b0, 3'b011, 64'h100, 64'h0);
        serveAccess(2, 64'hFEDCBA9876543210, ok, we, a, wd);
        assertCount++; if (!ok || {rsp_valid, rsp_err} !== 2'b10) begin failCount++; $display("[TB] FAIL rstmid_ld: got ok=%b v=%b e=%b expected 1 1 0", ok, rsp_valid, rsp_err); end
        assertCount++; if (rsp_rdata !== 64'hFEDCBA9876543210) begin failCount++; $display("[TB] FAIL rstmid_data: got %h expected fedcba9876543210", rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_loads();
        test_rmw();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected $finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the multicycle RV64 datapath (ALUOut address, B-register store data, func3) and the 64-bit doubleword-addressed data memory.
- Handles byte/half/word/doubleword loads with sign or zero extension.
- Sub-doubleword stores use read-modify-write.
- Supports a variable-latency memory ack, and reports misalignment, illegal func3 and memory timeout to the control unit's exception path (cause register / EPC).

Parameters:
- MEM_TIMEOUT, 255: max cycles mem_req may stay high without mem_ack before an abort; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  datapath requests an access
- req_ready  out  1  unit idle and able to accept a request
- req_write  in  1  1 = store, 0 = load
- req_func3  in  3  RISC-V funct3 of the load/store
- req_addr  in  64  byte address (ALUOut)
- req_wdata  in  64  store data (B register), used from the LSBs
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  64  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid; access faulted
- rsp_cause  out  2  00 ok, 01 misaligned, 10 illegal func3, 11 timeout
- fault_addr  out  64  req_addr of the last faulting access
- mem_req  out  1  memory access request, held until ack
- mem_we  out  1  write strobe, valid while mem_req is high
- mem_addr  out  64  {addr[63:3],3'b000}
- mem_wdata  out  64  full doubleword to write
- mem_ack  in  1  one-cycle ack; for reads, mem_rdata is valid in the same cycle
- mem_rdata  in  64  read doubleword
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active low):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready = 1.
  - Captured registers and the timeout counter clear.
  - Reset mid-access drops mem_req immediately. No response is issued for the abandoned access.
- States: IDLE, RD, WR, RESP.
  - req_ready = (state == IDLE).
  - A request is accepted on req_valid & req_ready at cycle T. addr, func3, write and wdata are captured at T; later input changes are ignored.
- Decode at acceptance:
  - Load func3 111 is illegal. Store func3 1xx is illegal.
  - Misaligned: half with addr[0] != 0; word with addr[1:0] != 0; doubleword with addr[2:0] != 0.
  - Illegal func3 takes priority over misalignment.
- Error at acceptance:
  - Next state is RESP. No memory access is made.
  - fault_addr <= req_addr.
  - rsp_valid, rsp_err and rsp_cause are asserted at T+1.
- Load, or sd:
  - Next state is RD for a load, WR for sd.
  - mem_req is asserted from T+1. mem_we = 0 for a load, 1 for sd.
- sb/sh/sw:
  - RD, then WR.
  - On RD ack: merged = mem_rdata with byte lanes replaced by req_wdata bits placed at the byte offset.
  - mem_wdata = merged.
  - mem_req stays high across the RD-to-WR transition; mem_we rises in WR.
- Ack handling:
  - On mem_ack in RD (load): rsp_rdata is extracted from lane addr[2:0] (little-endian).
    - lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend; ld passes through.
    - The result is registered and presented with rsp_valid in RESP.
  - On mem_ack in WR: next state is RESP, with rsp_rdata = 0.
  - A mem_ack in the cycle mem_req first rises is legal. The minimum load latency is therefore rsp_valid at T+2.
- RESP:
  - rsp_valid is high for exactly one cycle, then the state returns to IDLE.
  - The next request can be accepted the following cycle. There is no back-to-back acceptance during RESP.
- Timeout:
  - A counter resets on each state entry and increments each cycle mem_req is high without mem_ack.
  - When the counter equals MEM_TIMEOUT: mem_req drops, next state is RESP, cause = 11, fault_addr is captured.
  - An RMW read timeout never issues the write.
- Spurious input: mem_ack while mem_req is low is ignored.
- Outputs are registered. mem_addr and mem_wdata are stable while mem_req is high.

Test Plan:
- After reset, write 0x1122334455667788 to 0x100 via sd; then ld 0x100 with 3-cycle ack latency → rsp_valid 1 pulse, rsp_rdata = 0x1122334455667788, rsp_err = 0.
- lb 0x107 with byte 0x88 at lane 7 → 0xFFFFFFFFFFFFFF88; lbu 0x107 → 0x88; lw 0x104 with upper word 0x80000001 → 0xFFFFFFFF80000001; lwu → 0x80000001.
- sh 0x102 with data 0xABCD over dword 0x1122334455667788 → one RD then one WR, mem_wdata = 0x11223344ABCD7788, mem_addr = 0x100.
- lw 0x102 → no mem_req, rsp_err = 1, cause 01, fault_addr = 0x102 at T+1. Store func3 100 → cause 10.
- MEM_TIMEOUT = 4, ack never given → mem_req high for 4 cycles then low, cause 11, state returns to IDLE. For sb, mem_we never asserts.
- Deassert reset low while in WR → mem_req = 0 immediately, req_ready = 1, no rsp_valid. A new ld after release completes normally.
